// File: rtl/osc_pkg.sv
// osc_pkg: FSM state encoding and constants shared by the programmable oscillator.
package osc_pkg;
  typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_e;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/osc.sv
// osc: programmable clock generator with start-up phase offset and glitch-free stop.
module osc
  import osc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] phase_offset,
  output logic             clk,
  output logic             rise,
  output logic             fall
);
  state_e           state_q;
  logic [WIDTH-1:0] cnt_q, p_q, p_eff, h_m1, l_m1;
  logic             clk_q, rise_q, fall_q;
  assign p_eff = (period < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : period;
  assign h_m1  = (p_eff >> 1) - WIDTH'(1);
  // Low time uses the period latched on entry to HIGH, so mid-cycle changes wait a cycle.
  assign l_m1  = p_q - (p_q >> 1) - WIDTH'(1);
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= WIDTH'(MIN_PERIOD);
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE: if (enable) begin
          state_q <= PHASE;
          cnt_q   <= phase_offset;
        end
        PHASE, LOW: if (!enable) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          clk_q   <= 1'b0;
        end else if (cnt_q == '0) begin
          state_q <= HIGH;
          p_q     <= p_eff;
          cnt_q   <= h_m1;
          clk_q   <= 1'b1;
          rise_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q - WIDTH'(1);
        end
        HIGH: if (cnt_q == '0) begin
          state_q <= enable ? LOW : IDLE;
          cnt_q   <= enable ? l_m1 : '0;
          clk_q   <= 1'b0;
          fall_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q - WIDTH'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign clk  = clk_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: tb/tb_osc.sv
// tb_osc: directed self-checking bench for osc with hand-computed edge timings.
module tb_osc;
  localparam int W = 8;
  logic         ref_clk = 1'b0;
  logic         rst, enable;
  logic [W-1:0] period, phase_offset;
  logic         clk, rise, fall;
  int           checks = 0, failures = 0;
  int           n;
  osc #(.WIDTH(W)) dut (
    .ref_clk(ref_clk), .rst(rst), .enable(enable), .period(period),
    .phase_offset(phase_offset), .clk(clk), .rise(rise), .fall(fall)
  );
  always #5 ref_clk = ~ref_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic start(input logic [W-1:0] p, input logic [W-1:0] off);
    period = p;
    phase_offset = off;
    enable = 1'b1;
    tick();
  endtask
  // Edges from now until the requested strobe; -1 when the bound expires.
  task automatic wait_edge(input bit want_rise, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(want_rise ? rise : fall) && cnt < 1000);
    if (!(want_rise ? rise : fall)) cnt = -1;
  endtask
  initial begin
    rst = 1'b1; enable = 1'b1; period = 4; phase_offset = 0;
    tick(); tick();
    check("rst_clk", clk, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    do_reset();
    start(4, 0);
    check("p4_edge0_clk", clk, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("p4_clk_%0d", i), clk, ((i - 1) % 4) < 2);
      check($sformatf("p4_rise_%0d", i), rise, ((i - 1) % 4) == 0);
      check($sformatf("p4_fall_%0d", i), fall, ((i - 1) % 4) == 2);
    end
    enable = 1'b0;
    tick();
    check("p4_stop_low", clk, 0);
    do_reset();
    start(58, 10);
    wait_edge(1, n); check("p58_first_rise", n, 11);
    wait_edge(0, n); check("p58_high", n, 29);
    wait_edge(1, n); check("p58_low", n, 29);
    wait_edge(0, n); check("p58_high2", n, 29);
    do_reset();
    start(7, 0);
    wait_edge(1, n); check("p7_first_rise", n, 1);
    tick();
    check("p7_rise_one_cycle", rise, 0);
    check("p7_clk_still_high", clk, 1);
    wait_edge(0, n); check("p7_high", n, 2);
    tick();
    check("p7_fall_one_cycle", fall, 0);
    wait_edge(1, n); check("p7_low", n, 3);
    for (int p = 0; p < 2; p++) begin
      do_reset();
      start(W'(p), 0);
      wait_edge(1, n); check($sformatf("p%0d_first_rise", p), n, 1);
      wait_edge(0, n); check($sformatf("p%0d_high", p), n, 1);
      wait_edge(1, n); check($sformatf("p%0d_low", p), n, 1);
    end
    do_reset();
    start(142, 0);
    wait_edge(1, n); check("chg_first_rise", n, 1);
    period = 58;
    wait_edge(0, n); check("chg_high_old", n, 71);
    wait_edge(1, n); check("chg_low_old", n, 71);
    wait_edge(0, n); check("chg_high_new", n, 29);
    wait_edge(1, n); check("chg_low_new", n, 29);
    do_reset();
    start(10, 0);
    wait_edge(1, n);
    tick();
    enable = 1'b0;
    wait_edge(0, n); check("stop_high_total", n + 1, 5);
    check("stop_clk_low", clk, 0);
    for (int i = 0; i < 6; i++) tick();
    check("stop_idle_clk", clk, 0);
    check("stop_idle_rise", rise, 0);
    start(10, 3);
    wait_edge(1, n); check("reen_rise", n, 4);
    do_reset();
    start(10, 0);
    wait_edge(1, n);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_clk", clk, 0);
    check("midrst_rise", rise, 0);
    check("midrst_fall", fall, 0);
    rst = 1'b0;
    phase_offset = 0;
    tick();
    check("postrst_edge0", clk, 0);
    tick();
    check("postrst_clk", clk, 1);
    check("postrst_rise", rise, 1);
    do_reset();
    start(255, 255);
    wait_edge(1, n); check("max_off_rise", n, 256);
    wait_edge(0, n); check("max_p_high", n, 127);
    wait_edge(1, n); check("max_p_low", n, 128);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
